// File: rtl/eth_udp_rx_parser.sv
// Receive-side parser: frames the CDC byte stream by idle gaps, checks the Ethernet/IPv4/UDP
// headers and streams the matching UDP payload with SOF/EOF markers.
module eth_udp_rx_parser #(
    parameter logic [15:0] UDP_DST_PORT = 16'd12345,
    parameter int          IDLE_GAP     = 6
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    output logic [7:0] payloadDataOut,
    output logic       payloadValidOut,
    output logic       payloadSofOut,
    output logic       payloadEofOut,
    output logic       frameDropOut,
    output logic       truncErrOut
);

    localparam logic [3:0] GAP_MAX = 4'(IDLE_GAP);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN} ParseState;

    ParseState   state, stateNext;
    logic [3:0]  gapCnt, gapCntNext;
    logic [5:0]  byteCnt, byteCntNext;
    logic [15:0] payRem, payRemNext;
    logic [2:0]  pre, preNext;
    logic [7:0]  hiByte, hiByteNext;
    logic [15:0] udpLen, udpLenNext;
    logic        firstPay, firstPayNext;
    logic        frameEnd, hdrFail;
    logic [7:0]  dataNext;
    logic        validNext, sofNext, eofNext, dropNext, truncNext;

    // End of frame is the single cycle where the idle run reaches IDLE_GAP.
    assign frameEnd = !validIn && (gapCnt == GAP_MAX - 4'd1);

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state           <= IDLE;
            gapCnt          <= GAP_MAX;
            byteCnt         <= '0;
            payRem          <= '0;
            pre             <= '0;
            hiByte          <= '0;
            udpLen          <= '0;
            firstPay        <= 1'b0;
            payloadDataOut  <= '0;
            payloadValidOut <= 1'b0;
            payloadSofOut   <= 1'b0;
            payloadEofOut   <= 1'b0;
            frameDropOut    <= 1'b0;
            truncErrOut     <= 1'b0;
        end else begin
            state           <= stateNext;
            gapCnt          <= gapCntNext;
            byteCnt         <= byteCntNext;
            payRem          <= payRemNext;
            pre             <= preNext;
            hiByte          <= hiByteNext;
            udpLen          <= udpLenNext;
            firstPay        <= firstPayNext;
            payloadDataOut  <= dataNext;
            payloadValidOut <= validNext;
            payloadSofOut   <= sofNext;
            payloadEofOut   <= eofNext;
            frameDropOut    <= dropNext;
            truncErrOut     <= truncNext;
        end
    end

    always_comb begin
        stateNext    = state;
        gapCntNext   = validIn ? 4'd0 : ((gapCnt == GAP_MAX) ? GAP_MAX : gapCnt + 4'd1);
        byteCntNext  = byteCnt;
        payRemNext   = payRem;
        preNext      = pre;
        hiByteNext   = hiByte;
        udpLenNext   = udpLen;
        firstPayNext = firstPay;
        hdrFail      = 1'b0;
        dataNext     = '0;
        validNext    = 1'b0;
        sofNext      = 1'b0;
        eofNext      = 1'b0;
        dropNext     = 1'b0;
        truncNext    = 1'b0;

        if (frameEnd) begin
            stateNext = IDLE;
            truncNext = (state == HEADER) || (state == PAYLOAD);
        end else if (validIn) begin
            case (state)
                IDLE: begin
                    if (dataIn == 8'h55) begin
                        stateNext = PREAMBLE;
                        preNext   = 3'd1;
                    end else begin
                        stateNext = DRAIN;
                        dropNext  = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (dataIn == 8'h55 && pre < 3'd7) begin
                        preNext = pre + 3'd1;
                    end else if (dataIn == 8'hD5) begin
                        stateNext   = HEADER;
                        byteCntNext = '0;
                    end else begin
                        stateNext = DRAIN;
                        dropNext  = 1'b1;
                    end
                end
                HEADER: begin
                    byteCntNext = byteCnt + 6'd1;
                    // 16-bit fields are judged on their low byte, so the high byte is held over.
                    case (byteCnt)
                        6'd12, 6'd36, 6'd38: hiByteNext = dataIn;
                        6'd13: hdrFail = ({hiByte, dataIn} != 16'h0800);
                        6'd14: hdrFail = (dataIn != 8'h45);
                        6'd23: hdrFail = (dataIn != 8'h11);
                        6'd37: hdrFail = ({hiByte, dataIn} != UDP_DST_PORT);
                        6'd39: begin
                            hdrFail    = ({hiByte, dataIn} < 16'd9);
                            udpLenNext = {hiByte, dataIn};
                        end
                        6'd41: begin
                            stateNext    = PAYLOAD;
                            payRemNext   = udpLen - 16'd8;
                            firstPayNext = 1'b1;
                        end
                        default: ;
                    endcase
                    if (hdrFail) begin
                        stateNext = DRAIN;
                        dropNext  = 1'b1;
                    end
                end
                PAYLOAD: begin
                    dataNext     = dataIn;
                    validNext    = 1'b1;
                    sofNext      = firstPay;
                    firstPayNext = 1'b0;
                    payRemNext   = payRem - 16'd1;
                    if (payRem == 16'd1) begin
                        eofNext   = 1'b1;
                        stateNext = DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_udp_rx_parser.sv
// Directed bench for eth_udp_rx_parser: builds frames byte by byte at half rate and checks
// payload beats, markers and pulse timing against hand-derived expectations.
module tb_eth_udp_rx_parser;

    localparam int IDLE_GAP = 6;

    logic       clkIn = 1'b0;
    logic       rstIn;
    logic [7:0] dataIn;
    logic       validIn;
    logic [7:0] payloadDataOut;
    logic       payloadValidOut, payloadSofOut, payloadEofOut, frameDropOut, truncErrOut;

    eth_udp_rx_parser #(.UDP_DST_PORT(16'd12345), .IDLE_GAP(IDLE_GAP)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .validIn(validIn),
        .payloadDataOut(payloadDataOut), .payloadValidOut(payloadValidOut),
        .payloadSofOut(payloadSofOut), .payloadEofOut(payloadEofOut),
        .frameDropOut(frameDropOut), .truncErrOut(truncErrOut)
    );

    always #2 clkIn = ~clkIn;

    int total = 0;
    int bad = 0;
    int cycCnt = 0;

    always @(posedge clkIn) cycCnt <= cycCnt + 1;

    // Output monitor, sampled on the falling edge.
    int beatCnt = 0, sofCnt = 0, eofCnt = 0, sofEofCnt = 0, dropCnt = 0, truncCnt = 0;
    int backToBack = 0, bothPulse = 0, dropCycle = -1, truncCycle = -1;
    int sofData = -1, eofData = -1;
    logic prevValid = 1'b0;
    logic [7:0] payQ[$];

    always @(negedge clkIn) begin
        if (payloadValidOut) begin
            beatCnt++;
            payQ.push_back(payloadDataOut);
            if (payloadSofOut) begin sofCnt++; sofData = int'(payloadDataOut); end
            if (payloadEofOut) begin eofCnt++; eofData = int'(payloadDataOut); end
            if (payloadSofOut && payloadEofOut) sofEofCnt++;
            if (prevValid) backToBack++;
        end
        prevValid = payloadValidOut;
        if (frameDropOut) begin dropCnt++; dropCycle = cycCnt; end
        if (truncErrOut) begin truncCnt++; truncCycle = cycCnt; end
        if (frameDropOut && truncErrOut) bothPulse++;
    end

    logic [7:0] frameQ[$];
    int edgeQ[$];
    int baseBeat, baseSof, baseEof, baseSofEof, baseDrop, baseTrunc;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        dataIn  = b;
        validIn = 1'b1;
        @(posedge clkIn); #1;
        edgeQ.push_back(cycCnt);
        validIn = 1'b0;
        dataIn  = 8'h00;
        @(posedge clkIn); #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin @(posedge clkIn); #1; end
    endtask

    task automatic buildFrame(input logic [15:0] ethType, input logic [7:0] ihl, input logic [7:0] proto,
                              input logic [15:0] dstPort, input logic [15:0] udpLen,
                              input int nPay, input int nFcs);
        logic [7:0] pat [4];
        logic [7:0] hdr [42];
        pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frameQ.delete();
        repeat (7) frameQ.push_back(8'h55);
        frameQ.push_back(8'hD5);
        for (int i = 0; i < 42; i++) hdr[i] = (i < 12) ? 8'(i + 1) : 8'h00;
        hdr[12] = ethType[15:8]; hdr[13] = ethType[7:0];
        hdr[14] = ihl;           hdr[23] = proto;
        hdr[34] = 8'h30;         hdr[35] = 8'h39;
        hdr[36] = dstPort[15:8]; hdr[37] = dstPort[7:0];
        hdr[38] = udpLen[15:8];  hdr[39] = udpLen[7:0];
        for (int i = 0; i < 42; i++) frameQ.push_back(hdr[i]);
        for (int i = 0; i < nPay; i++) frameQ.push_back((i < 4) ? pat[i] : 8'(8'h10 + i));
        for (int i = 0; i < nFcs; i++) frameQ.push_back(8'(8'h11 * (i + 1)));
    endtask

    // gap = total idle cycles after the last byte (one comes from applyStimulus itself).
    task automatic sendFrame(input int gap);
        edgeQ.delete();
        foreach (frameQ[i]) applyStimulus(frameQ[i]);
        idleCycles(gap - 1);
    endtask

    task automatic snap();
        baseBeat = beatCnt; baseSof = sofCnt; baseEof = eofCnt;
        baseSofEof = sofEofCnt; baseDrop = dropCnt; baseTrunc = truncCnt;
    endtask

    function automatic int payAt(input int i);
        return (payQ.size() > baseBeat + i) ? int'(payQ[baseBeat + i]) : -1;
    endfunction

    initial begin
        rstIn   = 1'b1;
        validIn = 1'b0;
        dataIn  = 8'h00;
        idleCycles(3);
        checkOutput("rst_valid", payloadValidOut, 0);
        checkOutput("rst_drop", frameDropOut, 0);
        checkOutput("rst_trunc", truncErrOut, 0);
        rstIn = 1'b0;
        idleCycles(2);

        // Good frame, 4-byte payload plus FCS.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 4);
        snap();
        sendFrame(10);
        checkOutput("t1_beats", beatCnt - baseBeat, 4);
        checkOutput("t1_sof", sofCnt - baseSof, 1);
        checkOutput("t1_eof", eofCnt - baseEof, 1);
        checkOutput("t1_sofData", sofData, 8'hDE);
        checkOutput("t1_eofData", eofData, 8'hEF);
        checkOutput("t1_pay0", payAt(0), 8'hDE);
        checkOutput("t1_pay1", payAt(1), 8'hAD);
        checkOutput("t1_pay2", payAt(2), 8'hBE);
        checkOutput("t1_pay3", payAt(3), 8'hEF);
        checkOutput("t1_pulses", (dropCnt - baseDrop) + (truncCnt - baseTrunc), 0);

        // Wrong destination port.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12346, 16'd12, 4, 4);
        snap();
        sendFrame(10);
        checkOutput("t2_beats", beatCnt - baseBeat, 0);
        checkOutput("t2_drops", dropCnt - baseDrop, 1);
        checkOutput("t2_dropCycle", dropCycle, edgeQ[8 + 37]);

        buildFrame(16'h86DD, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 4);
        snap();
        sendFrame(10);
        checkOutput("t3_ethDrops", dropCnt - baseDrop, 1);
        checkOutput("t3_ethCycle", dropCycle, edgeQ[8 + 13]);

        buildFrame(16'h0800, 8'h46, 8'h11, 16'd12345, 16'd12, 4, 4);
        snap();
        sendFrame(10);
        checkOutput("t3_ihlDrops", dropCnt - baseDrop, 1);
        checkOutput("t3_ihlCycle", dropCycle, edgeQ[8 + 14]);

        buildFrame(16'h0800, 8'h45, 8'h06, 16'd12345, 16'd12, 4, 4);
        snap();
        sendFrame(10);
        checkOutput("t3_protoDrops", dropCnt - baseDrop, 1);
        checkOutput("t3_protoCycle", dropCycle, edgeQ[8 + 23]);
        checkOutput("t3_beats", beatCnt - baseBeat, 0);

        // Truncated payload: 5 of 12 bytes, then silence.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd20, 5, 0);
        snap();
        sendFrame(10);
        checkOutput("t4_beats", beatCnt - baseBeat, 5);
        checkOutput("t4_sof", sofCnt - baseSof, 1);
        checkOutput("t4_eof", eofCnt - baseEof, 0);
        checkOutput("t4_trunc", truncCnt - baseTrunc, 1);
        checkOutput("t4_truncCycle", truncCycle, edgeQ[edgeQ.size() - 1] + IDLE_GAP);
        checkOutput("t4_drops", dropCnt - baseDrop, 0);

        // Back-to-back frames: exact gap, then one cycle short.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 4);
        snap();
        sendFrame(IDLE_GAP);
        sendFrame(10);
        checkOutput("t5_gapOkBeats", beatCnt - baseBeat, 8);
        checkOutput("t5_gapOkSof", sofCnt - baseSof, 2);
        snap();
        sendFrame(IDLE_GAP - 1);
        sendFrame(10);
        checkOutput("t5_gapShortBeats", beatCnt - baseBeat, 4);
        checkOutput("t5_gapShortSof", sofCnt - baseSof, 1);
        checkOutput("t5_gapShortDrops", dropCnt - baseDrop, 0);

        // Reset in the middle of the payload.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd12, 4, 4);
        snap();
        edgeQ.delete();
        for (int i = 0; i < 8 + 42 + 1; i++) applyStimulus(frameQ[i]);
        dataIn  = frameQ[51];
        validIn = 1'b1;
        @(posedge clkIn); #1;
        checkOutput("t6_validBeforeRst", payloadValidOut, 1);
        validIn = 1'b0;
        rstIn   = 1'b1;
        @(posedge clkIn); #1;
        checkOutput("t6_validInRst", payloadValidOut, 0);
        checkOutput("t6_sofInRst", payloadSofOut, 0);
        checkOutput("t6_dataInRst", payloadDataOut, 0);
        rstIn = 1'b0;
        for (int i = 52; i < frameQ.size(); i++) applyStimulus(frameQ[i]);
        idleCycles(9);
        checkOutput("t6_beats", beatCnt - baseBeat, 2);
        checkOutput("t6_eof", eofCnt - baseEof, 0);
        checkOutput("t6_drops", dropCnt - baseDrop, 1);
        checkOutput("t6_trunc", truncCnt - baseTrunc, 0);
        snap();
        sendFrame(10);
        checkOutput("t6_cleanBeats", beatCnt - baseBeat, 4);
        checkOutput("t6_cleanEof", eofCnt - baseEof, 1);

        // Minimum and below-minimum UDP length.
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd9, 1, 4);
        snap();
        sendFrame(10);
        checkOutput("t7_len9Beats", beatCnt - baseBeat, 1);
        checkOutput("t7_len9SofEof", sofEofCnt - baseSofEof, 1);
        buildFrame(16'h0800, 8'h45, 8'h11, 16'd12345, 16'd8, 0, 4);
        snap();
        sendFrame(10);
        checkOutput("t7_len8Drops", dropCnt - baseDrop, 1);
        checkOutput("t7_len8Cycle", dropCycle, edgeQ[8 + 39]);
        checkOutput("t7_len8Beats", beatCnt - baseBeat, 0);

        checkOutput("backToBackValid", backToBack, 0);
        checkOutput("bothPulses", bothPulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
